// File: rtl/float_pkg.sv
// Shared single-precision definitions used by the int/float converters and other float units.
// Holds field widths, the exponent bias and helpers to split or pack a binary32 word.
package float_pkg;

    localparam int          SGL_EXP_BIAS = 127;
    localparam int          SGL_FRAC_W   = 23;
    localparam int          SGL_EXP_W    = 8;
    localparam logic [31:0] SGL_POS_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic                  sign;
        logic [SGL_EXP_W-1:0]  exp;
        logic [SGL_FRAC_W-1:0] frac;
    } sgl_t;

    function automatic logic sgl_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [SGL_EXP_W-1:0] sgl_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [SGL_FRAC_W-1:0] sgl_frac(input logic [31:0] f);
        return f[22:0];
    endfunction

    function automatic logic [31:0] sgl_pack(input logic                  sign,
                                             input logic [SGL_EXP_W-1:0]  exp,
                                             input logic [SGL_FRAC_W-1:0] frac);
        sgl_t r;
        r.sign = sign;
        r.exp  = exp;
        r.frac = frac;
        return r;
    endfunction

endpackage

// File: rtl/int_to_single_lzc32.sv
// Combinational 32-bit leading-zero counter built as a binary merge tree; count is 32 for zero input.
// Module name lzc32 so the float adder normaliser can reuse it unchanged.
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  count
);
    logic       zf_s  [6][32];
    logic [4:0] cnt_s [6][32];

    // Leaf n is bit 31-n; each level merges a left (more significant) and right child.
    always_comb begin
        for (int l = 0; l < 6; l++) begin
            for (int n = 0; n < 32; n++) begin
                zf_s[l][n]  = 1'b0;
                cnt_s[l][n] = 5'd0;
            end
        end
        for (int n = 0; n < 32; n++) begin
            zf_s[0][n] = ~a[31-n];
        end
        for (int l = 1; l < 6; l++) begin
            for (int n = 0; n < (32 >> l); n++) begin
                zf_s[l][n] = zf_s[l-1][2*n] & zf_s[l-1][2*n+1];
                if (!zf_s[l-1][2*n]) begin
                    cnt_s[l][n] = cnt_s[l-1][2*n];
                end else begin
                    cnt_s[l][n] = cnt_s[l-1][2*n+1] + (5'd1 << (l-1));
                end
            end
        end
        if (zf_s[5][0]) begin
            count = 6'd32;
        end else begin
            count = {1'b0, cnt_s[5][0]};
        end
    end

endmodule

// File: rtl/int_to_single.sv
// Three-stage signed 32-bit integer to binary32 converter, round-to-nearest-even.
// One global stall signal freezes every stage when the output is held by downstream.
module int_to_single
    import float_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int EXP_BIAS = SGL_EXP_BIAS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] int_to_single_a,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] int_to_single_z,
    output logic        out_valid,
    input  logic        out_ready
);

    if (WIDTH != 32) begin : g_width_check
        $error("int_to_single: only WIDTH=32 is supported");
    end

    localparam logic [7:0] EXP_TOP = 8'(EXP_BIAS + 31);

    logic        adv_s;
    logic        v1_r, v2_r, out_valid_r;
    logic        sign1_r, zero1_r;
    logic [31:0] mag1_r;
    logic        sign2_r, zero2_r;
    logic [31:0] norm2_r;
    logic [7:0]  exp2_r;
    logic [31:0] z_r;
    logic [5:0]  lz_s;
    logic [31:0] mag_s;
    logic [22:0] frac_s;
    logic        guard_s, sticky_s, round_up_s, is_zero_s;
    logic [23:0] frac_sum_s;
    logic [7:0]  exp_rnd_s;

    assign adv_s           = ~out_valid_r | out_ready;
    assign in_ready        = adv_s;
    assign out_valid       = out_valid_r;
    assign int_to_single_z = z_r;

    assign mag_s = int_to_single_a[31] ? (32'd0 - int_to_single_a) : int_to_single_a;

    lzc32 u_lzc (
        .a     (mag1_r),
        .count (lz_s)
    );

    // Rounding fields; a carry out of the fraction bumps the exponent and leaves frac at zero.
    always_comb begin
        frac_s     = norm2_r[30:8];
        guard_s    = norm2_r[7];
        sticky_s   = |norm2_r[6:0];
        round_up_s = guard_s & (sticky_s | frac_s[0]);
        frac_sum_s = {1'b0, frac_s} + {23'd0, round_up_s};
        exp_rnd_s  = exp2_r + {7'd0, frac_sum_s[23]};
        // Either the captured flag or a missing hidden bit marks a zero operand.
        is_zero_s  = zero2_r | ~norm2_r[31];
    end

    // Stage valid bits advance together under the global stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (adv_s) begin
            v1_r        <= in_valid;
            v2_r        <= v1_r;
            out_valid_r <= v2_r;
        end else begin
            v1_r        <= v1_r;
            v2_r        <= v2_r;
            out_valid_r <= out_valid_r;
        end
    end

    // Stage data: sign/magnitude, then normalisation, then the rounded packed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign1_r <= 1'b0;
            zero1_r <= 1'b0;
            mag1_r  <= 32'd0;
            sign2_r <= 1'b0;
            zero2_r <= 1'b0;
            norm2_r <= 32'd0;
            exp2_r  <= 8'd0;
            z_r     <= SGL_POS_ZERO;
        end else if (adv_s) begin
            sign1_r <= int_to_single_a[31];
            zero1_r <= (int_to_single_a == 32'd0);
            mag1_r  <= mag_s;
            sign2_r <= sign1_r;
            zero2_r <= zero1_r;
            norm2_r <= mag1_r << lz_s;
            exp2_r  <= EXP_TOP - {2'd0, lz_s};
            z_r     <= is_zero_s ? SGL_POS_ZERO : sgl_pack(sign2_r, exp_rnd_s, frac_sum_s[22:0]);
        end else begin
            sign1_r <= sign1_r;
            zero1_r <= zero1_r;
            mag1_r  <= mag1_r;
            sign2_r <= sign2_r;
            zero2_r <= zero2_r;
            norm2_r <= norm2_r;
            exp2_r  <= exp2_r;
            z_r     <= z_r;
        end
    end

endmodule

// File: tb/tb_int_to_single.sv
// Self-checking bench for int_to_single: directed vectors, backpressure, mid-flight reset, random traffic.
// Expected results come from an arithmetic round-to-nearest-even model and a queue of accepted operands.
module tb_int_to_single;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_a = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] z;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          out_xfer_cnt = 0;
    logic [31:0] exp_q[$];

    int_to_single dut (
        .clk             (clk),
        .rst             (rst),
        .int_to_single_a (in_a),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .int_to_single_z (z),
        .out_valid       (out_valid),
        .out_ready       (out_ready)
    );

    always #5 clk = ~clk;

    // Exact integer rounding: keep the top 24 significant bits, round the remainder half-to-even.
    function automatic logic [31:0] ref_conv(input logic [31:0] v);
        longint mag, q, rem, half;
        int     e, sh;
        logic   s;
        s   = v[31];
        mag = longint'($signed(v));
        if (mag < 64'sd0) mag = -mag;
        if (mag == 64'sd0) return 32'h0000_0000;
        e = 0;
        while ((64'sd1 <<< (e + 1)) <= mag) e++;
        if (e <= 23) begin
            q = mag <<< (23 - e);
        end else begin
            sh   = e - 23;
            q    = mag >>> sh;
            rem  = mag - (q <<< sh);
            half = 64'sd1 <<< (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'sd1;
            if (q == (64'sd1 <<< 24)) begin
                q = q >>> 1;
                e = e + 1;
            end
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h want %08h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Per-cycle compare: handshake rule, output against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", z, 32'hxxxx_xxxx);
                end else begin
                    check("z", z, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        out_xfer_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_conv(in_a));
        end
    end

    // Called just after a rising edge; returns just after the edge that took the operand.
    task automatic send(input logic [31:0] v);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_a     = v;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) fail_now("send_timeout");
    endtask

    task automatic drain();
        bit done;
        done      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0);
        end
        if (!done) fail_now("drain_timeout");
        repeat (6) @(posedge clk);
        #1;
    endtask

    logic [31:0] dir_a   [8] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'd16777217, 32'd16777219, 32'd16777221};
    logic [31:0] dir_exp [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000,
                                 32'h4F00_0000, 32'h4B80_0000, 32'h4B80_0002, 32'h4B80_0002};
    logic [31:0] bp_exp  [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                                 32'h4080_0000, 32'h40A0_0000};
    logic [31:0] specials[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'h0100_0000,
                                 32'h0100_0001, 32'hFEFF_FFFF};

    initial begin
        int lat;
        bit seen;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", z, 32'h0000_0000);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed values: pin the model, then check DUT result and 3-cycle latency
        for (int i = 0; i < 8; i++) begin
            check("model_directed", ref_conv(dir_a[i]), dir_exp[i]);
            send(dir_a[i]);
            lat  = 1;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1'b1;
                    check("directed_z", z, dir_exp[i]);
                end else begin
                    lat++;
                end
                @(posedge clk);
                #1;
            end
            if (!seen) fail_now("latency_wait");
            else check("latency", 32'(lat), 32'd3);
            drain();
        end

        // Backpressure: 1..5 streamed, out_ready low for four cycles
        for (int i = 0; i < 5; i++) check("model_bp", ref_conv(32'(i + 1)), bp_exp[i]);
        out_xfer_cnt = 0;
        fork
            begin
                for (int i = 1; i <= 5; i++) send(32'(i));
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_z", z, 32'h4000_0000);
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(out_xfer_cnt), 32'd5);

        // Reset mid-flight: three operands discarded, only 7 emerges
        send(32'd100);
        send(32'd200);
        send(32'd300);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_z", z, 32'h0000_0000);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_xfer_cnt = 0;
        check("model_seven", ref_conv(32'd7), 32'h40E0_0000);
        send(32'd7);
        drain();
        check("midrst_count", 32'(out_xfer_cnt), 32'd1);

        // Random traffic with random valid/ready
        for (int i = 0; i < 20000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       in_a = $urandom;
                1:       in_a = 32'($urandom_range(0, 33554432));
                2:       in_a = 32'd0 - 32'($urandom_range(0, 33554432));
                default: in_a = specials[$urandom_range(0, 5)];
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
